// File: rtl/axi_pattern_test_master_if.sv
// AXI write/read channel bundle used by the pattern test master.
// The master modport drives addresses, write data and response/read readies.
// The slave modport is the mirror image, for memory models or bridges.
interface axi_pattern_test_master_if #(
  parameter int A_WIDTH = 26,
  parameter int D_WIDTH = 16
);
  logic               awvalid;
  logic               awready;
  logic [A_WIDTH-1:0] awaddr;
  logic [7:0]         awlen;
  logic               wvalid;
  logic               wready;
  logic               wlast;
  logic [D_WIDTH-1:0] wdata;
  logic               bvalid;
  logic               bready;
  logic               arvalid;
  logic               arready;
  logic [A_WIDTH-1:0] araddr;
  logic [7:0]         arlen;
  logic               rvalid;
  logic               rready;
  logic               rlast;
  logic [D_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
           arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, arready, rvalid, rlast, rdata
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
           arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, arready, rvalid, rlast, rdata
  );
endinterface

// File: rtl/axi_pattern_test_master.sv
// AXI pattern test master: writes an address-derived pattern over the test
// region in bursts, reads it back and counts mismatches, for PASSES passes.
// Optional build macro AXI_PATTERN_ERR_CAPTURE_EN adds err_addr/err_exp/err_got,
// which hold the address, expected and received word of the first mismatch.
module axi_pattern_test_master #(
  parameter int         A_WIDTH      = 26,
  parameter int         D_WIDTH      = 16,
  parameter int         A_WIDTH_TEST = 12,
  parameter logic [7:0] WBURST_LEN   = 8'd7,
  parameter logic [7:0] RBURST_LEN   = 8'd7,
  parameter int         PASSES       = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic        mode,
  axi_pattern_test_master_if.master axi,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] error_cnt
`ifdef AXI_PATTERN_ERR_CAPTURE_EN
  ,
  output logic [A_WIDTH-1:0] err_addr,
  output logic [D_WIDTH-1:0] err_exp,
  output logic [D_WIDTH-1:0] err_got
`endif
);

  localparam int                      BYTES     = D_WIDTH / 8;
  localparam logic [A_WIDTH_TEST-1:0] ADDR_STEP = A_WIDTH_TEST'(BYTES);
  localparam logic [7:0]              LAST_PASS = 8'(PASSES - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [A_WIDTH_TEST-1:0] addr_q;     // byte address of the current beat
  logic [A_WIDTH_TEST-1:0] addr_inc;
  logic [7:0]              beat_q;
  logic [7:0]              pass_q;
  logic                    mode_q;
  logic                    error_q;
  logic [15:0]             err_cnt_q;
  logic [D_WIDTH-1:0]      addr_ext;
  logic [A_WIDTH-1:0]      addr_full;
  logic [D_WIDTH-1:0]      pattern;
  logic                    start_ok;
  logic                    w_fire;
  logic                    r_fire;
  logic                    mismatch;
  logic                    unused_rlast;

  // Read bursts end on our own beat count; the slave's rlast is not trusted.
  assign unused_rlast = axi.rlast;

  // Beat address widened/narrowed to data width and to bus address width.
  if (A_WIDTH_TEST >= D_WIDTH) begin : g_ext_trunc
    assign addr_ext = addr_q[D_WIDTH-1:0];
  end else begin : g_ext_zero
    assign addr_ext = {{(D_WIDTH - A_WIDTH_TEST){1'b0}}, addr_q};
  end
  if (A_WIDTH > A_WIDTH_TEST) begin : g_addr_zero
    assign addr_full = {{(A_WIDTH - A_WIDTH_TEST){1'b0}}, addr_q};
  end else begin : g_addr_trunc
    assign addr_full = addr_q[A_WIDTH-1:0];
  end

  assign addr_inc = addr_q + ADDR_STEP;
  assign pattern  = (addr_ext ^ {BYTES{pass_q}}) ^ {D_WIDTH{mode_q}};
  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
  assign w_fire   = (state_q == S_W) && axi.wready;
  assign r_fire   = (state_q == S_R) && axi.rvalid;
  assign mismatch = r_fire && (axi.rdata != pattern);

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; addr_q has already advanced past the burst in B.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_AW;
      S_AW:           if (axi.awready) state_d = S_W;
      S_W:            if (axi.wready && beat_q == WBURST_LEN) state_d = S_B;
      S_B:            if (axi.bvalid) state_d = (addr_q == '0) ? S_AR : S_AW;
      S_AR:           if (axi.arready) state_d = S_R;
      S_R: begin
        if (axi.rvalid && beat_q == RBURST_LEN) begin
          if (addr_inc != '0)            state_d = S_AR;
          else if (pass_q == LAST_PASS)  state_d = S_DONE;
          else                           state_d = S_AW;
        end
      end
      default:        state_d = S_IDLE;
    endcase
  end

  // Bus and status outputs decoded from the current state.
  always_comb begin
    axi.awvalid = (state_q == S_AW);
    axi.awaddr  = (state_q == S_AW) ? addr_full : '0;
    axi.awlen   = WBURST_LEN;
    axi.wvalid  = (state_q == S_W);
    axi.wlast   = (state_q == S_W) && (beat_q == WBURST_LEN);
    axi.wdata   = (state_q == S_W) ? pattern : '0;
    axi.bready  = (state_q == S_B);
    axi.arvalid = (state_q == S_AR);
    axi.araddr  = (state_q == S_AR) ? addr_full : '0;
    axi.arlen   = RBURST_LEN;
    axi.rready  = (state_q == S_R);
    busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    done        = (state_q == S_DONE);
  end

  // Beat address, beat counter, pass counter and captured mode.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q <= '0;
      beat_q <= '0;
      pass_q <= '0;
      mode_q <= 1'b0;
    end else if (start_ok) begin
      addr_q <= '0;
      beat_q <= '0;
      pass_q <= '0;
      mode_q <= mode;
    end else if (w_fire) begin
      addr_q <= addr_inc;
      beat_q <= (beat_q == WBURST_LEN) ? 8'd0 : beat_q + 8'd1;
    end else if (r_fire) begin
      addr_q <= addr_inc;
      beat_q <= (beat_q == RBURST_LEN) ? 8'd0 : beat_q + 8'd1;
      if (beat_q == RBURST_LEN && addr_inc == '0) pass_q <= pass_q + 8'd1;
    end
  end

  // Sticky error flag and saturating mismatch counter, cleared by a new run.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (start_ok) begin
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (mismatch) begin
      error_q <= 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign error     = error_q;
  assign error_cnt = err_cnt_q;

`ifdef AXI_PATTERN_ERR_CAPTURE_EN
  logic [A_WIDTH-1:0] err_addr_q;
  logic [D_WIDTH-1:0] err_exp_q;
  logic [D_WIDTH-1:0] err_got_q;

  // First mismatch of a run: captured only while the error flag is still clear.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else if (start_ok) begin
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else if (mismatch && !error_q) begin
      err_addr_q <= addr_full;
      err_exp_q  <= pattern;
      err_got_q  <= axi.rdata;
    end
  end

  assign err_addr = err_addr_q;
  assign err_exp  = err_exp_q;
  assign err_got  = err_got_q;
`endif

endmodule
